// File: rtl/serial_saturating_left_shift_pkg.sv
// Shared types and saturation helpers for the serial saturating left shifter.
// Holds the FSM state encoding and the signed saturation bound functions.
// The functions return 64-bit values, so callers cast them to their own width.
package serial_saturating_left_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest positive value of an n-bit signed number: 011..1
  function automatic logic [63:0] sat_max(input int n);
    return (64'(1) << (n - 1)) - 64'(1);
  endfunction

  // Most negative value of an n-bit signed number: 100..0
  function automatic logic [63:0] sat_min(input int n);
    return 64'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/serial_saturating_left_shift_step.sv
// One arithmetic left-shift step with zero fill, plus overflow detection.
// Purely combinational, so it adds no latency.
// step_ovf flags a step that would change the sign: the top two bits differ.
module serial_shl_step
  import serial_saturating_left_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] acc,
  output logic [N-1:0] acc_next,
  output logic         step_ovf
);

  assign acc_next = {acc[N-2:0], 1'b0};
  assign step_ovf = acc[N-1] ^ acc[N-2];

endmodule

// File: rtl/serial_saturating_left_shift.sv
// Computes saturate(a * 2**s) with one shift step per clock; valid/ready on both sides.
// Latency: accept in cycle k, result valid in cycle k+1+min(s,N).
// Backpressure: the result holds in DONE until out_ready; no new request is taken meanwhile.
module serial_saturating_left_shift
  import serial_saturating_left_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic          out_ovf
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] SAT_MAX = N'(sat_max(N));
  localparam logic [N-1:0] SAT_MIN = N'(sat_min(N));

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_next;
  logic          sign;
  logic          ovf;
  logic          step_ovf;
  logic          ovf_final;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_load;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign ovf_final = ovf | step_ovf;

  serial_shl_step #(.N(N)) u_step (
    .acc      (acc),
    .acc_next (acc_next),
    .step_ovf (step_ovf)
  );

  // Cap the step count at N: N steps already expose every overflow.
  always_comb begin
    cnt_load = CW'(N);
    if (32'(in_s) < N) cnt_load = CW'(in_s);
  end

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (cnt_load == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift in SHIFT, register the saturated result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sign    <= 1'b0;
      ovf     <= 1'b0;
      cnt     <= '0;
      out_res <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= in_a;
            sign <= in_a[N-1];
            cnt  <= cnt_load;
            ovf  <= 1'b0;
            if (cnt_load == '0) begin
              out_res <= in_a;
              out_ovf <= 1'b0;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          ovf <= ovf_final;
          if (cnt == CW'(1)) begin
            out_res <= ovf_final ? (sign ? SAT_MIN : SAT_MAX) : acc_next;
            out_ovf <= ovf_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
